mf_clkgen_nco_multi: RTL and testbench
======================================

Name: mf_clkgen_nco_multi

Overview:
- Parametrised, fully synthesizable multi-channel fractional clock generator. Acts as the soft successor to the fixed 3-output PLL wrapper.
- Runs on one reference clock. Each channel has a runtime-programmable phase accumulator (NCO) producing a clock-enable strobe and a ~50% square clock: f_out = f_refclk * inc / 2^ACC_W.
- Channel ratios and phase offsets can be reprogrammed at run time. Every reprogram re-aligns all channels and re-runs a settle/lock sequence.
- Feeds audio/pixel clock-enable consumers that currently depend on fixed PLL outputs.

Parameters:
- NUM_CH, 3, number of output channels (1..16).
- ACC_W, 32, accumulator/increment/phase width in bits (8..48).
- SETTLE_CYCLES, 16, refclk cycles from alignment to locked assertion (>=1).

Ports:
- refclk  in  1  block clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write may be accepted this cycle.
- cfg_ch  in  max(1,clog2(NUM_CH))  target channel index.
- cfg_inc  in  ACC_W  per-cycle phase increment.
- cfg_phase  in  ACC_W  phase loaded at alignment.
- cfg_en  in  1  channel enable.
- ce  out  NUM_CH  per-channel one-cycle strobe on accumulator wrap.
- clk_out  out  NUM_CH  per-channel accumulator MSB.
- locked  out  1  all channels aligned and settled.

Behaviour:
- Reset (rst=1 at an edge):
  - FSM=UNLOCKED; all shadow inc/phase/en=0; all acc=0; settle counter=0.
  - Outputs: ce=0, clk_out=0, locked=0, cfg_ready=1.
  - Reset wins over any simultaneous cfg write. Reset mid-operation discards all config.
- Handshake:
  - A write is accepted when cfg_valid & cfg_ready at an edge.
  - cfg_ready is combinational: it is 0 only in ALIGN. A held cfg_valid is accepted the following cycle.
- Accepted write, cfg_ch < NUM_CH:
  - Shadow inc/phase/en of that channel updated.
  - FSM -> ALIGN; locked <= 0 at the same edge.
- Accepted write, cfg_ch >= NUM_CH: dropped; no state, lock or shadow change.
- FSM:
  - UNLOCKED: acc held 0; ce=0; clk_out=0. Exits only on a valid write.
  - ALIGN (exactly one edge):
    - Each enabled acc <= phase; each disabled acc <= 0.
    - ce <= 0; clk_out <= MSB of the loaded acc value.
    - Counter <= SETTLE_CYCLES-1; -> SETTLE.
  - SETTLE: channels run; counter decrements each edge.
    - At an edge with counter==0: -> LOCKED, locked <= 1.
    - A valid write -> ALIGN (restart).
  - LOCKED: channels run; locked=1. A valid write -> ALIGN.
- Channel update at each edge in SETTLE/LOCKED, for an enabled channel:
  - {carry, sum} = acc + inc, computed ACC_W+1 bits wide.
  - acc <= sum, i.e. mod 2^ACC_W wrap.
  - ce <= carry; clk_out <= sum[ACC_W-1].
- Disabled channel: acc=0, ce=0, clk_out=0.
- inc=0 on an enabled channel: acc frozen at phase; ce never asserts.
- Timing:
  - Write accepted at edge E0; align at E1; locked rises at E(SETTLE_CYCLES+1).
  - ce/clk_out are registered, with 0-cycle latency from the acc update.
- Shadow updates only change live channels through ALIGN. Writes never alter a running accumulator in place.
- ce strobes are coincident across channels whose ratios share a wrap. There is no cross-channel arbitration.

Decomposition:
- Package mf_clkgen_pkg:
  - FSM enum (UNLOCKED, ALIGN, SETTLE, LOCKED).
  - Function for the cfg_ch width, max(1,clog2(NUM_CH)).
  - Default constants for ACC_W and SETTLE_CYCLES.
- Sub-module mf_clkgen_nco_ch: one channel with acc, shadow regs, align/run/clear controls, and ce/clk_out regs. Instantiated NUM_CH times via generate.
- Top level owns the FSM, settle counter, handshake and locked.

Test Plan (NUM_CH=3, ACC_W=8, SETTLE_CYCLES=4):
- Reset: assert rst 2 cycles, release -> ce=000, clk_out=000, locked=0, cfg_ready=1. All stay so for 20 cycles with no writes.
- Single channel: write ch0 inc=64 phase=0 en=1 at E0 -> cfg_ready=0 during ALIGN cycle only. Locked rises after E5. ch0 clk_out reads 0,1,1,0 after E2..E5, then repeats with period 4. ce0 high after E5, E9, E13.
- Phase offset: additionally write ch1 inc=64 phase=128 en=1 -> after realign, clk_out[1] = ~clk_out[0] every cycle. ce1 is 2 cycles ahead of ce0. Locked re-rises 5 edges after the second write.
- Fractional: ch2 inc=3 -> over 256 running cycles ce2 pulses exactly 3 times, with pulse spacing 85 or 86 cycles.
- Restart/backpressure: issue a write during SETTLE with cfg_valid held 2 cycles -> accepted once, then a second acceptance after ALIGN. Locked stays 0 and rises 5 edges after the last acceptance. Write cfg_ch=3 while LOCKED -> locked stays 1 and outputs are unperturbed.
- Reset mid-LOCKED: rst for 1 edge -> next cycle all outputs 0 and locked=0. A fresh write is required to restart; no prior config survives.

Source files
------------

// File: rtl/mf_clkgen_pkg.sv
// rtl/mf_clkgen_pkg.sv - shared types, defaults and width helper for the multi-channel NCO clock generator
package mf_clkgen_pkg;

    localparam int DEF_ACC_W         = 32;
    localparam int DEF_SETTLE_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_LOCKED   = 2'd3
    } clkgen_state_t;

    // Index width that never collapses to zero bits, so single-entry
    // configurations still get a real port.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mf_clkgen_nco_ch.sv
// rtl/mf_clkgen_nco_ch.sv - one NCO channel: shadow config, phase accumulator, ce/clk_out registers
//
// Ports:
//   clk, rst            reference clock, synchronous active-high reset
//   wr                  load shadow inc/phase/en from wr_* this edge
//   align               load accumulator from shadow (phase or 0 when disabled)
//   run                 advance accumulator by shadow increment
//   clear               hold accumulator and outputs at 0
//   ce                  one-cycle strobe on accumulator wrap
//   clk_out             accumulator MSB
module mf_clkgen_nco_ch #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic [ACC_W-1:0] wr_phase,
    input  logic             wr_en,
    input  logic             align,
    input  logic             run,
    input  logic             clear,
    output logic             ce,
    output logic             clk_out
);

    logic [ACC_W-1:0] inc_sh;
    logic [ACC_W-1:0] phase_sh;
    logic             en_sh;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // Shadow registers: a write only lands here; the live accumulator picks
    // it up on the next align so running channels are never disturbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_sh   <= '0;
            phase_sh <= '0;
            en_sh    <= 1'b0;
        end else if (wr) begin
            inc_sh   <= wr_inc;
            phase_sh <= wr_phase;
            en_sh    <= wr_en;
        end
    end

    // One extra bit captures the wrap carry that becomes ce.
    assign sum = {1'b0, acc} + {1'b0, inc_sh};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc     <= '0;
            ce      <= 1'b0;
            clk_out <= 1'b0;
        end else if (align) begin
            acc     <= en_sh ? phase_sh : '0;
            ce      <= 1'b0;
            clk_out <= en_sh & phase_sh[ACC_W-1];
        end else if (run) begin
            if (en_sh) begin
                acc     <= sum[ACC_W-1:0];
                ce      <= sum[ACC_W];
                clk_out <= sum[ACC_W-1];
            end else begin
                acc     <= '0;
                ce      <= 1'b0;
                clk_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mf_clkgen_nco_multi.sv
// rtl/mf_clkgen_nco_multi.sv - multi-channel fractional clock generator with align/settle/lock sequencing
//
// Ports:
//   refclk, rst         reference clock, synchronous active-high reset
//   cfg_valid/ready     config write handshake (ready low only while aligning)
//   cfg_ch              target channel; out-of-range writes are dropped
//   cfg_inc/phase/en    per-channel increment, alignment phase, enable
//   ce                  per-channel wrap strobe
//   clk_out             per-channel ~50% clock (accumulator MSB)
//   locked              all channels aligned and settle time elapsed
module mf_clkgen_nco_multi
    import mf_clkgen_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int ACC_W         = DEF_ACC_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int CH_W         = ch_idx_w(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int            CNT_W    = ch_idx_w(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(NUM_CH);

    clkgen_state_t    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             accept;
    logic             valid_wr;

    assign cfg_ready = (state != ST_ALIGN);
    assign accept    = cfg_valid & cfg_ready;
    // Widened compare so a full power-of-two channel count never truncates.
    assign valid_wr  = accept & ({1'b0, cfg_ch} < CH_LIM);
    assign locked    = (state == ST_LOCKED);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= ST_UNLOCKED;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_UNLOCKED: begin
                if (valid_wr) state_n = ST_ALIGN;
            end
            ST_ALIGN: begin
                cnt_n   = CNT_INIT;
                state_n = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (valid_wr) begin
                    state_n = ST_ALIGN;
                end else if (cnt == '0) begin
                    state_n = ST_LOCKED;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (valid_wr) state_n = ST_ALIGN;
            end
            default: state_n = ST_UNLOCKED;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mf_clkgen_nco_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk      (refclk),
            .rst      (rst),
            .wr       (valid_wr && (cfg_ch == CH_W'(g))),
            .wr_inc   (cfg_inc),
            .wr_phase (cfg_phase),
            .wr_en    (cfg_en),
            .align    (state == ST_ALIGN),
            .run      ((state == ST_SETTLE) || (state == ST_LOCKED)),
            .clear    (state == ST_UNLOCKED),
            .ce       (ce[g]),
            .clk_out  (clk_out[g])
        );
    end

endmodule

// File: tb/tb_mf_clkgen_nco_multi.sv
// tb/tb_mf_clkgen_nco_multi.sv - directed self-checking bench for mf_clkgen_nco_multi
module tb_mf_clkgen_nco_multi;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 8;
    localparam int SETTLE = 4;

    logic        refclk    = 1'b0;
    logic        rst       = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch    = '0;
    logic [7:0]  cfg_inc   = '0;
    logic [7:0]  cfg_phase = '0;
    logic        cfg_en    = 1'b0;
    logic        cfg_ready;
    logic [2:0]  ce;
    logic [2:0]  clk_out;
    logic        locked;

    int checks   = 0;
    int failures = 0;
    int m_inc [NUM_CH];
    int m_ph  [NUM_CH];
    int m_en  [NUM_CH];

    mf_clkgen_nco_multi #(
        .NUM_CH        (NUM_CH),
        .ACC_W         (ACC_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_en    (cfg_en),
        .ce        (ce),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_inc[i] = 0;
            m_ph[i]  = 0;
            m_en[i]  = 0;
        end
    endtask

    // n = running edges since the align edge (0 = just aligned).
    task automatic expect_ch(input string tag, input int n);
        logic [2:0] ece;
        logic [2:0] eclk;
        int         acc_now;
        int         acc_prev;
        ece  = '0;
        eclk = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_en[i] != 0) begin
                acc_now  = m_ph[i] + m_inc[i] * n;
                acc_prev = m_ph[i] + m_inc[i] * (n - 1);
                eclk[i]  = (acc_now % 256) >= 128;
                ece[i]   = (n >= 1) && ((acc_now / 256) != (acc_prev / 256));
            end
        end
        chk({tag, "_ce"}, 32'(ce), 32'(ece));
        chk({tag, "_clk"}, 32'(clk_out), 32'(eclk));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_ce"}, 32'(ce), 32'd0);
        chk({tag, "_clk"}, 32'(clk_out), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    // Returns just after the align edge for an in-range channel.
    task automatic cfg_write(input int ch, input int inc, input int ph, input bit en);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_inc   = 8'(inc);
        cfg_phase = 8'(ph);
        cfg_en    = en;
        chk("wr_ready_pre", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        m_inc[ch] = inc;
        m_ph[ch]  = ph;
        m_en[ch]  = int'(en);
        chk("wr_ready_align", 32'(cfg_ready), 32'd0);
        chk("wr_locked_drop", 32'(locked), 32'd0);
        step();
        chk("wr_ready_post", 32'(cfg_ready), 32'd1);
        expect_ch("wr_aligned", 0);
    endtask

    initial begin
        int cnt;
        int last;

        model_clear();

        // Reset, then quiet idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        expect_idle("reset");
        for (int k = 0; k < 20; k++) begin
            step();
            expect_idle("idle");
        end

        // Single channel, inc=64 -> period 4
        cfg_write(0, 64, 0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            expect_ch("single", k);
            chk("single_locked", 32'(locked), 32'(k >= SETTLE));
        end

        // Second channel half a period offset
        cfg_write(1, 64, 128, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_ch("phase", k);
            chk("phase_locked", 32'(locked), 32'(k >= SETTLE));
        end

        // Fractional ratio 3/256
        cfg_write(2, 3, 0, 1'b1);
        cnt  = 0;
        last = 0;
        for (int k = 1; k <= 256; k++) begin
            step();
            expect_ch("frac", k);
            if (ce[2]) begin
                if (cnt > 0) chk("frac_gap", 32'((k - last) inside {85, 86}), 32'd1);
                cnt++;
                last = k;
            end
        end
        chk("frac_count", 32'(cnt), 32'd3);

        // Restart during SETTLE with a held request
        cfg_write(0, 64, 0, 1'b1);
        step();
        expect_ch("settle", 1);
        chk("settle_locked", 32'(locked), 32'd0);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_inc   = 8'd32;
        cfg_phase = 8'd0;
        cfg_en    = 1'b1;
        chk("hold_ready0", 32'(cfg_ready), 32'd1);
        step();
        expect_ch("hold_a0", 2);
        chk("hold_ready1", 32'(cfg_ready), 32'd0);
        m_inc[0] = 32;
        step();
        expect_ch("hold_a1", 0);
        chk("hold_ready2", 32'(cfg_ready), 32'd1);
        chk("hold_locked2", 32'(locked), 32'd0);
        step();
        cfg_valid = 1'b0;
        expect_ch("hold_a2", 1);
        chk("hold_ready3", 32'(cfg_ready), 32'd0);
        step();
        expect_ch("hold_a3", 0);
        chk("hold_ready4", 32'(cfg_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            expect_ch("relock", k);
            chk("relock_locked", 32'(locked), 32'(k >= SETTLE));
        end

        // Out-of-range channel while LOCKED is ignored
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_inc   = 8'd200;
        cfg_phase = 8'd77;
        cfg_en    = 1'b0;
        chk("drop_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        expect_ch("drop", 5);
        chk("drop_locked", 32'(locked), 32'd1);
        chk("drop_ready_after", 32'(cfg_ready), 32'd1);
        for (int k = 6; k <= 10; k++) begin
            step();
            expect_ch("drop_run", k);
            chk("drop_run_locked", 32'(locked), 32'd1);
        end

        // Reset while LOCKED discards everything
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        expect_idle("midrst");
        for (int k = 0; k < 8; k++) begin
            step();
            expect_idle("midrst_idle");
        end

        // Fresh start: only the newly written channels run
        cfg_write(1, 64, 0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            expect_ch("fresh", k);
            chk("fresh_locked", 32'(locked), 32'(k >= SETTLE));
        end

        // Zero increment freezes at phase, never strobes
        cfg_write(2, 0, 144, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            expect_ch("zero_inc", k);
            chk("zero_inc_locked", 32'(locked), 32'(k >= SETTLE));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
